// File: rtl/f_mult_pipe.sv
// Three-stage IEEE-754 multiplier (classify/multiply, normalise, round) for any EXP_W/MAN_W format.
// Latency 3 cycles from accept to out_valid; one op per cycle; the whole pipe freezes while the output is held.
module f_mult_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic [2:0]             rounding,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   y,
    output logic [4:0]             flags
);
    localparam int W       = 1 + EXP_W + MAN_W;
    localparam int SW      = MAN_W + 1;
    localparam int PW      = 2 * SW;
    localparam int EW2     = EXP_W + 2;
    localparam int LZ_W    = $clog2(PW);
    localparam int EN_W    = EW2 + LZ_W + 1;
    localparam int SH_W    = $clog2(MAN_W + 4);
    localparam int BIAS    = 2**(EXP_W-1) - 1;
    localparam int EXP_MAX = 2**EXP_W - 1;

    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [W-2:0] INF_MAG = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
    localparam logic [W-2:0] MAX_MAG = {{(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};

    logic w_stall;
    assign w_stall   = out_valid & ~out_ready;
    assign in_ready  = ~reset & ~w_stall;

    // ---------------- S1: classify, exponent sum, significand product
    logic             w_sa, w_sb, w_sign;
    logic [EXP_W-1:0] w_ea, w_eb, w_a_e, w_b_e;
    logic [MAN_W-1:0] w_ma, w_mb;
    logic             w_a_nan, w_a_snan, w_a_inf, w_a_zero, w_a_expz;
    logic             w_b_nan, w_b_snan, w_b_inf, w_b_zero, w_b_expz;
    logic [SW-1:0]    w_a_sig, w_b_sig;
    logic             w_spec, w_spec_nv;
    logic [W-1:0]     w_spec_y;
    logic signed [EW2-1:0] w_e;
    logic [PW-1:0]    w_prod;

    assign {w_sa, w_ea, w_ma} = a;
    assign {w_sb, w_eb, w_mb} = b;
    assign w_sign   = w_sa ^ w_sb;

    assign w_a_expz = ~|w_ea;
    assign w_a_nan  = (&w_ea) & (|w_ma);
    assign w_a_snan = w_a_nan & ~w_ma[MAN_W-1];
    assign w_a_inf  = (&w_ea) & ~(|w_ma);
    assign w_a_zero = w_a_expz & ~(|w_ma);
    assign w_a_sig  = {~w_a_expz, w_ma};
    assign w_a_e    = w_a_expz ? EXP_W'(1) : w_ea;

    assign w_b_expz = ~|w_eb;
    assign w_b_nan  = (&w_eb) & (|w_mb);
    assign w_b_snan = w_b_nan & ~w_mb[MAN_W-1];
    assign w_b_inf  = (&w_eb) & ~(|w_mb);
    assign w_b_zero = w_b_expz & ~(|w_mb);
    assign w_b_sig  = {~w_b_expz, w_mb};
    assign w_b_e    = w_b_expz ? EXP_W'(1) : w_eb;

    assign w_e    = EW2'(w_a_e) + EW2'(w_b_e) - EW2'(BIAS);
    assign w_prod = PW'(w_a_sig) * PW'(w_b_sig);

    always_comb begin
        w_spec    = 1'b0;
        w_spec_nv = 1'b0;
        w_spec_y  = '0;
        if (w_a_nan | w_b_nan) begin
            w_spec    = 1'b1;
            w_spec_y  = QNAN;
            w_spec_nv = w_a_snan | w_b_snan;
        end else if ((w_a_inf & w_b_zero) | (w_a_zero & w_b_inf)) begin
            w_spec    = 1'b1;
            w_spec_y  = QNAN;
            w_spec_nv = 1'b1;
        end else if (w_a_inf | w_b_inf) begin
            w_spec    = 1'b1;
            w_spec_y  = {w_sign, INF_MAG};
        end else if (w_a_zero | w_b_zero) begin
            w_spec    = 1'b1;
            w_spec_y  = {w_sign, {(W-1){1'b0}}};
        end
    end

    logic                  r1_vld, r1_sign, r1_spec, r1_spec_nv;
    logic [W-1:0]          r1_spec_y;
    logic [2:0]            r1_rm;
    logic signed [EW2-1:0] r1_e;
    logic [PW-1:0]         r1_prod;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r1_vld     <= 1'b0;
            r1_sign    <= 1'b0;
            r1_spec    <= 1'b0;
            r1_spec_nv <= 1'b0;
            r1_spec_y  <= '0;
            r1_rm      <= '0;
            r1_e       <= '0;
            r1_prod    <= '0;
        end else if (!w_stall) begin
            r1_vld     <= in_valid;
            r1_sign    <= w_sign;
            r1_spec    <= w_spec;
            r1_spec_nv <= w_spec_nv;
            r1_spec_y  <= w_spec_y;
            r1_rm      <= rounding;
            r1_e       <= w_e;
            r1_prod    <= w_prod;
        end
    end

    // ---------------- S2: normalise, denormalise tiny results, collect guard/round/sticky
    logic [LZ_W-1:0]       w_lz;
    logic [PW-1:0]         w_norm, w_den, w_sel;
    logic signed [EN_W-1:0] w_en;
    logic [EN_W-1:0]       w_shf;
    logic [SH_W-1:0]       w_sh;
    logic                  w_tiny, w_lost;

    always_comb begin
        w_lz = '0;
        for (int i = 0; i < PW; i++) begin
            if (r1_prod[i]) w_lz = LZ_W'(PW - 1 - i);
        end
    end

    // Biased exponent of a value whose leading one sits at the product MSB.
    assign w_en   = EN_W'(r1_e) + EN_W'(1) - EN_W'(w_lz);
    assign w_norm = r1_prod << w_lz;
    assign w_tiny = w_en[EN_W-1] | (w_en == '0);
    assign w_shf  = EN_W'(1) - w_en;
    assign w_sh   = (w_shf > EN_W'(MAN_W + 3)) ? SH_W'(MAN_W + 3) : SH_W'(w_shf);
    assign w_den  = w_norm >> w_sh;
    assign w_lost = |(w_norm & ((PW'(1) << w_sh) - PW'(1)));
    assign w_sel  = w_tiny ? w_den : w_norm;

    logic                  r2_vld, r2_sign, r2_spec, r2_spec_nv, r2_tiny;
    logic [W-1:0]          r2_spec_y;
    logic [2:0]            r2_rm;
    logic [MAN_W:0]        r2_mant;
    logic                  r2_g, r2_r, r2_s;
    logic [EN_W-1:0]       r2_exp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r2_vld     <= 1'b0;
            r2_sign    <= 1'b0;
            r2_spec    <= 1'b0;
            r2_spec_nv <= 1'b0;
            r2_tiny    <= 1'b0;
            r2_spec_y  <= '0;
            r2_rm      <= '0;
            r2_mant    <= '0;
            r2_g       <= 1'b0;
            r2_r       <= 1'b0;
            r2_s       <= 1'b0;
            r2_exp     <= '0;
        end else if (!w_stall) begin
            r2_vld     <= r1_vld;
            r2_sign    <= r1_sign;
            r2_spec    <= r1_spec;
            r2_spec_nv <= r1_spec_nv;
            r2_tiny    <= w_tiny;
            r2_spec_y  <= r1_spec_y;
            r2_rm      <= r1_rm;
            r2_mant    <= w_sel[PW-1:MAN_W+1];
            r2_g       <= w_sel[MAN_W];
            r2_r       <= w_sel[MAN_W-1];
            r2_s       <= (|w_sel[MAN_W-2:0]) | (w_tiny & w_lost);
            r2_exp     <= w_tiny ? '0 : w_en;
        end
    end

    // ---------------- S3: round, overflow saturation, specials override
    logic             w_inex, w_inc, w_ovf, w_ovf_inf;
    logic [MAN_W+1:0] w_sum;
    logic [EN_W-1:0]  w_exp_r;
    logic [W-1:0]     w_y;
    logic [4:0]       w_flags;

    assign w_inex = r2_g | r2_r | r2_s;

    always_comb begin
        w_inc     = r2_g & (r2_r | r2_s | r2_mant[0]);
        w_ovf_inf = 1'b1;
        case (r2_rm)
            3'b001: begin w_inc = 1'b0;               w_ovf_inf = 1'b0;     end
            3'b010: begin w_inc = r2_sign & w_inex;   w_ovf_inf = r2_sign;  end
            3'b011: begin w_inc = ~r2_sign & w_inex;  w_ovf_inf = ~r2_sign; end
            3'b100: begin w_inc = r2_g;                                     end
            default: ;
        endcase
    end

    // A subnormal that rounds up into the hidden-bit position becomes the smallest normal.
    assign w_sum   = {1'b0, r2_mant} + (MAN_W+2)'(w_inc);
    assign w_exp_r = (r2_exp == '0) ? EN_W'(w_sum[MAN_W]) : r2_exp + EN_W'(w_sum[MAN_W+1]);
    assign w_ovf   = w_exp_r >= EN_W'(EXP_MAX);

    always_comb begin
        w_y     = {r2_sign, w_exp_r[EXP_W-1:0], w_sum[MAN_W-1:0]};
        w_flags = {3'b000, r2_tiny & w_inex, w_inex};
        if (r2_spec) begin
            w_y     = r2_spec_y;
            w_flags = {r2_spec_nv, 4'b0000};
        end else if (w_ovf) begin
            w_y     = {r2_sign, w_ovf_inf ? INF_MAG : MAX_MAG};
            w_flags = 5'b00101;
        end
    end

    logic         r3_vld;
    logic [W-1:0] r3_y;
    logic [4:0]   r3_flags;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r3_vld   <= 1'b0;
            r3_y     <= '0;
            r3_flags <= '0;
        end else if (!w_stall) begin
            r3_vld   <= r2_vld;
            r3_y     <= w_y;
            r3_flags <= w_flags;
        end
    end

    assign out_valid = r3_vld;
    assign y         = r3_y;
    assign flags     = r3_flags;

endmodule

// File: tb/tb_f_mult_pipe.sv
// Scoreboard bench for f_mult_pipe (binary32): directed vectors, stall, and mid-flight reset.
module tb_f_mult_pipe;
    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, y;
    logic [2:0]  rounding;
    logic [4:0]  flags;

    f_mult_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .rounding(rounding), .out_valid(out_valid),
        .out_ready(out_ready), .y(y), .flags(flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ey;
        logic [4:0]  ef;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   n_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: output must match the scoreboard head every cycle it is presented.
    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_output: got y=%h flags=%b, expected no result", y, flags);
                end else begin
                    check("y", y, sb[0].ey);
                    check("flags", {27'b0, flags}, {27'b0, sb[0].ef});
                    if (out_ready) begin
                        if (sb[0].lat) check("latency", 32'(cyc - sb[0].acc), 32'd3);
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic [2:0] rm,
                         input logic [31:0] ey, input logic [4:0] ef, input bit lat);
        int waited = 0;
        bit done   = 0;
        a = ia; b = ib; rounding = rm; in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1;
                sb.push_back('{ey, ef, cyc, lat});
                n_acc++;
            end else if (++waited > 50) begin
                done = 1;
                n_cmp++;
                n_err++;
                $display("FAIL accept_timeout: in_ready stuck at %b, expected 1", in_ready);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int w = 0;
        while (sb.size() != 0 && w < 100) begin
            @(posedge clk);
            w++;
        end
        #1;
        check("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; rounding = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_y", y, 32'd0);
        check("rst_flags", {27'b0, flags}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // Directed vectors, back to back at full throughput.
        issue(32'h3FC00000, 32'h40000000, 3'b000, 32'h40400000, 5'b00000, 1);
        issue(32'h7F800000, 32'h00000000, 3'b000, 32'h7FC00000, 5'b10000, 1);
        issue(32'h7F800001, 32'h3F800000, 3'b000, 32'h7FC00000, 5'b10000, 1);
        issue(32'h7FC00000, 32'h3F800000, 3'b000, 32'h7FC00000, 5'b00000, 1);
        issue(32'hFF800000, 32'h00000000, 3'b000, 32'h7FC00000, 5'b10000, 1);
        issue(32'hFF800000, 32'h40000000, 3'b000, 32'hFF800000, 5'b00000, 1);
        issue(32'h80000000, 32'h3F800000, 3'b000, 32'h80000000, 5'b00000, 1);
        issue(32'h7F7FFFFF, 32'h40000000, 3'b000, 32'h7F800000, 5'b00101, 1);
        issue(32'h7F7FFFFF, 32'h40000000, 3'b001, 32'h7F7FFFFF, 5'b00101, 1);
        issue(32'hFF7FFFFF, 32'h40000000, 3'b010, 32'hFF800000, 5'b00101, 1);
        issue(32'h7F7FFFFF, 32'h40000000, 3'b010, 32'h7F7FFFFF, 5'b00101, 1);
        issue(32'h00800000, 32'h3F000000, 3'b000, 32'h00400000, 5'b00000, 1);
        issue(32'h00000001, 32'h3F000000, 3'b000, 32'h00000000, 5'b00011, 1);
        issue(32'h00000001, 32'h3F000000, 3'b011, 32'h00000001, 5'b00011, 1);
        issue(32'h007FFFFF, 32'h3F800001, 3'b000, 32'h00800000, 5'b00011, 1);
        issue(32'h3F800003, 32'h3FC00000, 3'b000, 32'h3FC00004, 5'b00001, 1);
        issue(32'h3F800003, 32'h3FC00000, 3'b100, 32'h3FC00005, 5'b00001, 1);
        issue(32'h3F800003, 32'h3FC00000, 3'b011, 32'h3FC00005, 5'b00001, 1);
        issue(32'h3F800003, 32'h3FC00000, 3'b010, 32'h3FC00004, 5'b00001, 1);
        issue(32'hBF800003, 32'h3FC00000, 3'b010, 32'hBFC00005, 5'b00001, 1);
        issue(32'h3F800003, 32'h3FC00000, 3'b101, 32'h3FC00004, 5'b00001, 1);
        wait_drain();

        // Five back-to-back ops with the consumer stalled for five cycles.
        base = n_acc;
        fork
            begin
                issue(32'h3F800000, 32'h40000000, 3'b000, 32'h40000000, 5'b00000, 0);
                issue(32'h3F800000, 32'h40400000, 3'b000, 32'h40400000, 5'b00000, 0);
                issue(32'h3F800000, 32'h40800000, 3'b000, 32'h40800000, 5'b00000, 0);
                issue(32'h3F800000, 32'h40A00000, 3'b000, 32'h40A00000, 5'b00000, 0);
                issue(32'h3F800000, 32'h40C00000, 3'b000, 32'h40C00000, 5'b00000, 0);
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                @(negedge clk);
                check("stall_in_ready", {31'b0, in_ready}, 32'd0);
                check("stall_accepted", 32'(n_acc - base), 32'd3);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // Reset with two ops in flight: neither may ever emerge.
        issue(32'h3FC00000, 32'h40000000, 3'b000, 32'h40400000, 5'b00000, 0);
        issue(32'h40000000, 32'h40000000, 3'b000, 32'h40800000, 5'b00000, 0);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        check("flush_out_valid", {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check("flush_out_valid_edge", {31'b0, out_valid}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("flush_in_ready", {31'b0, in_ready}, 32'd1);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("flush_no_output", {31'b0, out_valid}, 32'd0);
        check("flush_pending", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
